// File: rtl/tag_freelist.sv
// Tag free-list: a circular RAM of free tags with a show-ahead allocation
// window at the head, a compacting multi-port release path at the tail,
// and a single head-pointer checkpoint for speculative allocation rollback.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tag_freelist #(
    parameter int TAG_W       = 8,
    parameter int DEPTH       = 128,
    parameter int ALLOC_PORTS = 2,
    parameter int FREE_PORTS  = 2,
    parameter int INIT_BASE   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [$clog2(ALLOC_PORTS+1)-1:0]   alloc_cnt,
    output logic [ALLOC_PORTS*TAG_W-1:0]       alloc_tag,
    output logic                               alloc_ok,
    input  logic [FREE_PORTS-1:0]              free_valid,
    input  logic [FREE_PORTS*TAG_W-1:0]        free_tag,
    input  logic                               ckpt_save,
    input  logic                               ckpt_restore,
    output logic [$clog2(DEPTH):0]             freespace,
    output logic                               overflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(ALLOC_PORTS + 1);
    localparam int FC_W  = $clog2(FREE_PORTS + 1);
    localparam int SUM_W = PTR_W + 1;

    // Count of set bits in the release strobe vector.
    function automatic logic [FC_W-1:0] popcount_f(input logic [FREE_PORTS-1:0] v);
        logic [FC_W-1:0] c;
        c = {FC_W{1'b0}};
        for (int i = 0; i < FREE_PORTS; i++) begin
            c = c + FC_W'(v[i]);
        end
        return c;
    endfunction

    logic [TAG_W-1:0] ram_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W-1:0] snap_r;
    logic [PTR_W-1:0] freespace_r;
    logic             overflow_r;

    logic             cnt_legal_s;
    logic             fits_s;
    logic             alloc_ok_s;
    logic [PTR_W-1:0] grant_s;
    logic [FC_W-1:0]  free_cnt_s;
    logic [SUM_W-1:0] occ_sum_s;
    logic             drop_s;
    logic [PTR_W-1:0] head_adv_s;
    logic [PTR_W-1:0] head_nxt_s;
    logic [PTR_W-1:0] tail_nxt_s;
    logic [PTR_W-1:0] snap_nxt_s;
    logic [IDX_W-1:0] rd_idx_s   [ALLOC_PORTS];
    logic [IDX_W-1:0] free_idx_s [FREE_PORTS];
    logic [ALLOC_PORTS*TAG_W-1:0] alloc_tag_s;

    // Grant decision, overflow detection and next-state pointer arithmetic.
    always_comb begin
        cnt_legal_s = (alloc_cnt != {CNT_W{1'b0}}) &&
                      (alloc_cnt <= CNT_W'(ALLOC_PORTS));
        fits_s      = (32'(alloc_cnt) <= 32'(freespace_r));
        alloc_ok_s  = cnt_legal_s && fits_s && !ckpt_restore;
        grant_s     = alloc_ok_s ? PTR_W'(alloc_cnt) : {PTR_W{1'b0}};
        free_cnt_s  = popcount_f(free_valid);
        // grant never exceeds freespace, so the subtraction cannot underflow
        occ_sum_s   = SUM_W'(freespace_r) - SUM_W'(grant_s) + SUM_W'(free_cnt_s);
        drop_s      = (occ_sum_s > SUM_W'(DEPTH));
        head_adv_s  = head_r + grant_s;
        head_nxt_s  = ckpt_restore ? snap_r : head_adv_s;
        if (ckpt_restore) begin
            snap_nxt_s = snap_r;
        end else if (ckpt_save) begin
            snap_nxt_s = head_adv_s;
        end else begin
            snap_nxt_s = snap_r;
        end
        tail_nxt_s  = drop_s ? tail_r : (tail_r + PTR_W'(free_cnt_s));
    end

    // Compaction: each strobed slot lands at tail plus the number of lower strobed slots.
    always_comb begin
        logic [PTR_W-1:0] off;
        off = {PTR_W{1'b0}};
        for (int j = 0; j < FREE_PORTS; j++) begin
            free_idx_s[j] = IDX_W'(tail_r + off);
            if (free_valid[j]) begin
                off = off + PTR_W'(1);
            end else begin
                off = off;
            end
        end
    end

    // Show-ahead read window starting at head, independent of the request size.
    always_comb begin
        alloc_tag_s = {(ALLOC_PORTS*TAG_W){1'b0}};
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            rd_idx_s[i] = IDX_W'(head_r + PTR_W'(i));
            alloc_tag_s[i*TAG_W +: TAG_W] = ram_r[rd_idx_s[i]];
        end
    end

    // Tag storage: initial tag load on reset, compacted release writes otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ram_r[k] <= (k < DEPTH - INIT_BASE) ? TAG_W'(INIT_BASE + k) : {TAG_W{1'b0}};
            end
        end else if (!drop_s) begin
            for (int j = 0; j < FREE_PORTS; j++) begin
                if (free_valid[j]) begin
                    ram_r[free_idx_s[j]] <= free_tag[j*TAG_W +: TAG_W];
                end
            end
        end
    end

    // Pointer, checkpoint, occupancy and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= PTR_W'(DEPTH - INIT_BASE);
            snap_r      <= {PTR_W{1'b0}};
            freespace_r <= PTR_W'(DEPTH - INIT_BASE);
            overflow_r  <= 1'b0;
        end else begin
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            snap_r      <= snap_nxt_s;
            freespace_r <= tail_nxt_s - head_nxt_s;
            overflow_r  <= overflow_r | drop_s;
        end
    end

    assign alloc_ok  = alloc_ok_s;
    assign alloc_tag = alloc_tag_s;
    assign freespace = freespace_r;
    assign overflow  = overflow_r;

endmodule

// File: doc/tag_freelist.md
TAG_FREELIST -- requirements
Module: tag_freelist

Interface
REQ-001 SHALL have parameter TAG_W, default 8, tag width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, ring entries, power of two, DEPTH <= 2**TAG_W.
REQ-003 SHALL have parameter ALLOC_PORTS, default 2, maximum tags allocated per cycle (1..4).
REQ-004 SHALL have parameter FREE_PORTS, default 2, maximum tags released per cycle (1..4).
REQ-005 SHALL have parameter INIT_BASE, default 2, lowest tag loaded at reset; tags 0..INIT_BASE-1 are never loaded.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-007 SHALL have reset  in  1  synchronous active-high reset.
REQ-008 SHALL have alloc_cnt  in  clog2(ALLOC_PORTS+1)  number of tags requested this cycle.
REQ-009 SHALL have alloc_tag  out  ALLOC_PORTS*TAG_W  show-ahead tags, slot i = entry head+i.
REQ-010 SHALL have alloc_ok  out  1  combinational grant for this cycle's request.
REQ-011 SHALL have free_valid  in  FREE_PORTS  per-slot release strobe.
REQ-012 SHALL have free_tag  in  FREE_PORTS*TAG_W  released tags.
REQ-013 SHALL have ckpt_save  in  1  snapshot head pointer.
REQ-014 SHALL have ckpt_restore  in  1  roll head pointer back to snapshot.
REQ-015 SHALL have freespace  out  clog2(DEPTH)+1  registered count of free tags.
REQ-016 SHALL have overflow  out  1  sticky error flag.

Function
REQ-017 SHALL store tags in a DEPTH-entry circular RAM with head/tail pointers of clog2(DEPTH)+1 bits (extra wrap bit); freespace = tail - head.
REQ-018 SHALL present alloc_tag slots combinationally from RAM[head+i] regardless of alloc_cnt; slots beyond freespace are don't-care.
REQ-019 SHALL assert alloc_ok when alloc_cnt != 0, alloc_cnt <= freespace and ckpt_restore == 0; all-or-nothing, no partial grants.
REQ-020 SHALL, when alloc_ok, advance head by alloc_cnt at the next rising edge; otherwise head holds (except restore).
REQ-021 SHALL compact free_valid slots in ascending slot order and write them to RAM[tail], RAM[tail+1], ...; tail advances by popcount(free_valid).
REQ-022 SHALL, if freespace - granted_allocs + popcount(free_valid) > DEPTH, drop all frees that cycle and set overflow; overflow clears only on reset.
REQ-023 SHALL apply allocation and frees in the same cycle; freed tags are not visible on alloc_tag before the following cycle.
REQ-024 SHALL, on ckpt_save, capture the head value after this cycle's grant (head + granted count).
REQ-025 SHALL, on ckpt_restore, set head to the snapshot; ckpt_restore takes priority over ckpt_save and over allocation; frees still apply.
REQ-026 SHALL update freespace every cycle from next head/tail; pointer arithmetic wraps mod 2*DEPTH.
REQ-027 SHALL treat alloc_cnt > ALLOC_PORTS as alloc_cnt = 0 (no grant).

Reset
REQ-028 SHALL, on reset, load RAM[k] = INIT_BASE + k for k = 0..DEPTH-INIT_BASE-1, head = 0, tail = DEPTH-INIT_BASE, snapshot = 0, overflow = 0.
REQ-029 SHALL give freespace = DEPTH-INIT_BASE (126 for defaults) in the cycle after reset deasserts; reset overrides every other input in the same cycle.
REQ-030 SHALL, on reset mid-operation, discard all outstanding allocations and snapshot with no residual state.

Verification
REQ-031 SHALL cover: reset, no traffic -> freespace=126, alloc_tag slot0=0x02, slot1=0x03, overflow=0.
REQ-032 SHALL cover: alloc_cnt=2 every cycle for 63 cycles -> tags 0x02..0x7F in order, freespace=0, then alloc_cnt=1 gives alloc_ok=0.
REQ-033 SHALL cover: freespace=1, alloc_cnt=2 -> alloc_ok=0, head unchanged; same cycle free_valid=2'b01 tag 0x05 -> freespace=2 next cycle.
REQ-034 SHALL cover: ckpt_save with alloc_cnt=1 at head tag 0x02, then 3 single allocs, then ckpt_restore -> slot0=0x03, freespace=125.
REQ-035 SHALL cover: freespace=127, free_valid=2'b11 -> frees dropped, freespace=127, overflow=1 until reset.
REQ-036 SHALL cover: full drain and refill past entry 127 -> pointers wrap, freespace correct, tag order FIFO across wrap.
